// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_READ read ports, two prioritised write
// ports, optional bypass, zero register, pending scoreboard, sweep clear.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_READ*ADDR_W-1:0] rd_addr,
  output logic [NUM_READ*DATA_W-1:0] rd_data,
  output logic [NUM_READ-1:0]        rd_pend,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          wa0,
  input  logic [DATA_W-1:0]          wd0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          wa1,
  input  logic [DATA_W-1:0]          wd1,
  input  logic                       set_pend,
  input  logic [ADDR_W-1:0]          set_addr,
  input  logic                       clear_req,
  output logic                       init_done
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH-1);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W-1:0]   ptr_n;
  logic [DEPTH-1:0]    pend;
  logic [DEPTH-1:0]    pend_n;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic ready;
  logic wr_ok;
  logic w0;
  logic w1;

  assign ready     = (state == READY);
  assign init_done = ready;

  // A clear request drops any write or issue in the same cycle
  assign wr_ok = ready && !clear_req;
  assign w0    = wr_ok && we0 &&
                 !((ZERO_REG != 0) && (wa0 == '0));
  assign w1    = wr_ok && we1 &&
                 !((ZERO_REG != 0) && (wa1 == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= '0;
      pend  <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      pend  <= pend_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    unique case (state)
      CLEAR: begin
        ptr_n = ptr + ADDR_W'(1);
        if (ptr == LAST) begin
          state_n = READY;
          ptr_n   = '0;
        end
      end
      READY: begin
        if (clear_req) begin
          state_n = CLEAR;
          ptr_n   = '0;
        end
      end
      default: begin
        state_n = CLEAR;
        ptr_n   = '0;
      end
    endcase
  end

  // Set after clear: a newly issued producer supersedes a retiring one
  always_comb begin
    pend_n = pend;
    if (!wr_ok) begin
      pend_n = '0;
    end else begin
      if (w0)       pend_n[wa0]      = 1'b0;
      if (w1)       pend_n[wa1]      = 1'b0;
      if (set_pend) pend_n[set_addr] = 1'b1;
    end
    if (ZERO_REG != 0) pend_n[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[ptr] <= '0;
    end else begin
      if (w0) mem[wa0] <= wd0;
      if (w1) mem[wa1] <= wd1;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rv = mem[ra];
      if (BYPASS != 0) begin
        if (w0 && (wa0 == ra)) rv = wd0;
        if (w1 && (wa1 == ra)) rv = wd1;
      end
      if (!ready || ((ZERO_REG != 0) && (ra == '0))) rv = '0;
    end

    assign rd_data[k*DATA_W +: DATA_W] = rv;
    assign rd_pend[k] = ready && pend[ra];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default build plus a BYPASS=0, NUM_READ=4 build
// sharing the same write/control stimulus.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] ra0, ra1, ra2, ra3;
  logic [2*AW-1:0] rd_addr;
  logic [2*DW-1:0] rd_data;
  logic [1:0]      rd_pend;
  logic [4*AW-1:0] alt_addr;
  logic [4*DW-1:0] alt_data;
  logic [3:0]      alt_pend;
  logic          we0, we1, set_pend, clear_req;
  logic [AW-1:0] wa0, wa1, set_addr;
  logic [DW-1:0] wd0, wd1;
  logic          init_done, alt_done;

  int checks = 0;
  int errors = 0;

  assign rd_addr  = {ra1, ra0};
  assign alt_addr = {ra3, ra2, ra1, ra0};

  always #5 clk = ~clk;

  regfile_mp u_dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .set_pend(set_pend), .set_addr(set_addr),
    .clear_req(clear_req), .init_done(init_done)
  );

  regfile_mp #(.NUM_READ(4), .BYPASS(0)) u_alt (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(alt_addr), .rd_data(alt_data), .rd_pend(alt_pend),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .set_pend(set_pend), .set_addr(set_addr),
    .clear_req(clear_req), .init_done(alt_done)
  );

  typedef struct {
    logic          w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          sp;
    logic [AW-1:0] sa;
    logic [AW-1:0] r0;
    logic [AW-1:0] r1;
    logic [DW-1:0] x0;
    logic [DW-1:0] x1;
    logic [DW-1:0] xa;
    logic          p0;
    logic          p1;
  } vec_t;

  typedef struct {
    logic [DW-1:0] x0;
    logic [DW-1:0] x1;
    logic [DW-1:0] xa;
    logic          p0;
    logic          p1;
  } exp_t;

  vec_t vecs[16];
  exp_t sb[$];

  function automatic vec_t mk(
    input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
    input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
    input logic sp, input logic [AW-1:0] sa,
    input logic [AW-1:0] r0, input logic [AW-1:0] r1,
    input logic [DW-1:0] x0, input logic [DW-1:0] x1,
    input logic [DW-1:0] xa, input logic p0, input logic p1);
    vec_t v;
    v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.sp = sp; v.sa = sa; v.r0 = r0; v.r1 = r1;
    v.x0 = x0; v.x1 = x1; v.xa = xa; v.p0 = p0; v.p1 = p1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic idle();
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    set_pend = 1'b0; set_addr = '0;
    clear_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    // Each vector: inputs of one cycle, outputs seen before its edge
    vecs[0]  = mk(1, 7, 32'h11111111, 1, 7, 32'h22222222, 0, 0, 7, 7,
                  32'h22222222, 32'h22222222, 32'h0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 7, 0,
                  32'h22222222, 32'h0, 32'h22222222, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7,
                  32'h0, 32'h22222222, 32'h0, 0, 0);
    vecs[3]  = mk(1, 3, 32'h0000ABCD, 0, 0, 0, 0, 0, 3, 3,
                  32'h0000ABCD, 32'h0000ABCD, 32'h0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 7,
                  32'h0000ABCD, 32'h22222222, 32'h0000ABCD, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 1, 9, 9, 9,
                  32'h0, 32'h0, 32'h0, 0, 0);
    vecs[6]  = mk(1, 9, 32'h5, 0, 0, 0, 1, 9, 9, 9,
                  32'h5, 32'h5, 32'h0, 1, 1);
    vecs[7]  = mk(0, 0, 0, 1, 9, 32'h6, 0, 0, 9, 9,
                  32'h6, 32'h6, 32'h5, 1, 1);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 9, 0,
                  32'h6, 32'h0, 32'h6, 0, 0);
    vecs[9]  = mk(1, 4, 32'h55, 0, 0, 0, 1, 4, 0, 4,
                  32'h0, 32'h55, 32'h0, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 9,
                  32'h55, 32'h6, 32'h55, 1, 0);
    vecs[11] = mk(1, 5, 32'h1, 1, 6, 32'h2, 0, 0, 5, 6,
                  32'h1, 32'h2, 32'h0, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 6,
                  32'h1, 32'h2, 32'h1, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 1, 10, 10, 4,
                  32'h0, 32'h55, 32'h0, 0, 1);
    vecs[14] = mk(1, 10, 32'h7, 0, 0, 0, 0, 0, 10, 4,
                  32'h7, 32'h55, 32'h0, 1, 1);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 10, 4,
                  32'h7, 32'h55, 32'h7, 0, 1);

    idle();
    ra0 = '0; ra1 = '0; ra2 = '0; ra3 = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_init_done", init_done, 0);
    chk("rst_rd_pend", rd_pend, 0);
    chk("rst_rd_data", rd_data[DW-1:0], 0);

    // Reset sweep; a late write to r5 must not survive
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      idle();
      ra0 = 5'd5;
      ra1 = AW'(i);
      if (i == 20) begin
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD;
      end
      #1;
      chk("sweep_init_done", init_done, 0);
      chk("sweep_rd0", rd_data[DW-1:0], 0);
      chk("sweep_rd1", rd_data[2*DW-1:DW], 0);
      @(negedge clk);
    end
    idle();
    #1;
    chk("sweep_end_done", init_done, 1);
    chk("sweep_end_alt", alt_done, 1);
    chk("sweep_r5_lost", rd_data[DW-1:0], 0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      we0 = vecs[i].w0; wa0 = vecs[i].a0; wd0 = vecs[i].d0;
      we1 = vecs[i].w1; wa1 = vecs[i].a1; wd1 = vecs[i].d1;
      set_pend = vecs[i].sp; set_addr = vecs[i].sa;
      ra0 = vecs[i].r0; ra1 = vecs[i].r1;
      sb.push_back('{vecs[i].x0, vecs[i].x1, vecs[i].xa,
                     vecs[i].p0, vecs[i].p1});
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d_rd0", i), rd_data[DW-1:0], e.x0);
      chk($sformatf("v%0d_rd1", i), rd_data[2*DW-1:DW], e.x1);
      chk($sformatf("v%0d_alt0", i), alt_data[DW-1:0], e.xa);
      chk($sformatf("v%0d_pend0", i), rd_pend[0], e.p0);
      chk($sformatf("v%0d_pend1", i), rd_pend[1], e.p1);
      chk($sformatf("v%0d_altp0", i), alt_pend[0], e.p0);
    end

    // Clear request; same-cycle write and issue to r8 are dropped
    @(negedge clk);
    idle();
    clear_req = 1'b1;
    we0 = 1'b1; wa0 = 5'd8; wd0 = 32'h77;
    set_pend = 1'b1; set_addr = 5'd8;
    ra0 = 5'd4; ra1 = 5'd8;
    #1;
    chk("clr_pre_done", init_done, 1);
    chk("clr_pre_p4", rd_pend[0], 1);
    chk("clr_pre_r4", rd_data[DW-1:0], 32'h55);
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      idle();
      clear_req = (i == 5);
      #1;
      chk("clr_done_low", init_done, 0);
      chk("clr_pend_low", rd_pend[0], 0);
      @(negedge clk);
    end
    idle();
    #1;
    chk("clr_end_done", init_done, 1);
    chk("clr_r4", rd_data[DW-1:0], 0);
    chk("clr_p4", rd_pend[0], 0);
    chk("clr_r8", rd_data[2*DW-1:DW], 0);
    chk("clr_p8", rd_pend[1], 0);

    // Asynchronous reset while ready, then mid-sweep at ptr=10
    @(negedge clk);
    set_pend = 1'b1; set_addr = 5'd12;
    @(negedge clk);
    idle();
    ra0 = 5'd12;
    #1;
    chk("arst_pre_pend", rd_pend[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pend", rd_pend[0], 0);
    chk("arst_done", init_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mid_done", init_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("arst_sweep_done", init_done, 0);
      @(negedge clk);
    end
    #1;
    chk("arst_end_done", init_done, 1);
    chk("arst_end_p12", rd_pend[0], 0);

    // All four ports of the wide build
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd1; wd0 = 32'hA1A1A1A1;
    we1 = 1'b1; wa1 = 5'd2; wd1 = 32'hB2B2B2B2;
    @(negedge clk);
    wa0 = 5'd3; wd0 = 32'hC3C3C3C3;
    wa1 = 5'd4; wd1 = 32'hD4D4D4D4;
    @(negedge clk);
    idle();
    ra0 = 5'd1; ra1 = 5'd2; ra2 = 5'd3; ra3 = 5'd4;
    #1;
    chk("nr4_p0", alt_data[DW-1:0], 32'hA1A1A1A1);
    chk("nr4_p1", alt_data[2*DW-1:DW], 32'hB2B2B2B2);
    chk("nr4_p2", alt_data[3*DW-1:2*DW], 32'hC3C3C3C3);
    chk("nr4_p3", alt_data[4*DW-1:3*DW], 32'hD4D4D4D4);
    chk("nr4_main0", rd_data[DW-1:0], 32'hA1A1A1A1);
    chk("nr4_main1", rd_data[2*DW-1:DW], 32'hB2B2B2B2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
